// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory unit.
// Optional build macro: DMEM_BYTE_EN (per-byte write enables on RAM and IO_Out).
package dmem_pkg;

  // Sequencer states: zero the RAM after reset, then serve the core.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

  // Default byte address of the memory-mapped output register.
  localparam logic [31:0] DMEM_MMIO_ADDR_DEFAULT = 32'hFFFF_FFFC;

  // Width of the saturating accepted-write counter.
  localparam int WCOUNT_W = 16;

  // Bits needed to index a RAM of the given depth.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Clear sequencer: walks every RAM word once after reset, then raises ready.
// Optional build macro: DMEM_BYTE_EN (not used in this file).
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx
);

  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  // State and index registers; reset restarts the clear from word 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state and outputs: one zero-write per cycle, last index hands over to RUN.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign clr_idx = clr_idx_q;

endmodule

// File: rtl/data_memory_unit.sv
// Data-memory responder for the single-cycle MIPS core: word RAM with
// post-reset clear, one MMIO output register, sticky error flags and a
// saturating accepted-write counter.
// Optional build macro: DMEM_BYTE_EN adds the BE[3:0] byte-enable port.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 64,
  parameter logic [WIDTH-1:0] MMIO_ADDR = WIDTH'(DMEM_MMIO_ADDR_DEFAULT)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    WD,
  input  logic                WE,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]          BE,
`endif
  output logic [WIDTH-1:0]    RD,
  output logic                Ready,
  output logic [WIDTH-1:0]    IO_Out,
  output logic                Misaligned,
  output logic                Range_Err,
  output logic [WCOUNT_W-1:0] Write_Count
);

  localparam int             IDX_W     = idx_width(DEPTH);
  localparam logic [WIDTH:0] RANGE_END = (WIDTH + 1)'(4 * DEPTH);

  logic                ready;
  logic                clr_we;
  logic [IDX_W-1:0]    clr_idx;

  logic [WIDTH-1:0]    mem [DEPTH];

  logic [IDX_W-1:0]    word_idx;
  logic                in_range;
  logic                mmio_hit;
  logic                aligned;
  logic [WIDTH-1:0]    wmask;

  logic [WIDTH-1:0]    io_out_q, io_out_d;
  logic                misaligned_q, misaligned_d;
  logic                range_err_q, range_err_d;
  logic [WCOUNT_W-1:0] wr_count_q, wr_count_d;

  logic                run_mem_we;
  logic                accepted;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [WIDTH-1:0]    mem_wdata;

  dmem_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk     (CLK),
    .rst     (RST),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign word_idx = A[IDX_W+1:2];
  assign in_range = ({1'b0, A} < RANGE_END);
  assign mmio_hit = (A == MMIO_ADDR);
  assign aligned  = (A[1:0] == 2'b00);

`ifdef DMEM_BYTE_EN
  // Expand byte enables to a bit mask; BE[0] covers bits 7:0.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{BE[b]}};
    end
  end
`else
  assign wmask = '1;
`endif

  // Write decode in RUN: misalignment beats MMIO beats RAM beats range error.
  always_comb begin
    io_out_d     = io_out_q;
    misaligned_d = misaligned_q;
    range_err_d  = range_err_q;
    wr_count_d   = wr_count_q;
    run_mem_we   = 1'b0;
    accepted     = 1'b0;
    if (ready && WE) begin
      if (!aligned) begin
        misaligned_d = 1'b1;
      end else if (mmio_hit) begin
        io_out_d = (WD & wmask) | (io_out_q & ~wmask);
        accepted = 1'b1;
      end else if (in_range) begin
        run_mem_we = 1'b1;
        accepted   = 1'b1;
      end else begin
        range_err_d = 1'b1;
      end
    end
    if (accepted && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // RAM write-port mux: the clear sequencer owns the port until ready.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = (WD & wmask) | (mem[word_idx] & ~wmask);
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_widx  = clr_idx;
      mem_wdata = '0;
    end else if (run_mem_we) begin
      mem_we = 1'b1;
    end
  end

  // Control registers: MMIO output, sticky flags, write counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      io_out_q     <= '0;
      misaligned_q <= 1'b0;
      range_err_q  <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      io_out_q     <= io_out_d;
      misaligned_q <= misaligned_d;
      range_err_q  <= range_err_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // RAM storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset branch; the clear sequencer zeroes it, so it maps to plain RAM.
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Asynchronous read: zero while clearing or off the map.
  always_comb begin
    RD = '0;
    if (ready) begin
      if (mmio_hit) begin
        RD = io_out_q;
      end else if (in_range) begin
        RD = mem[word_idx];
      end
    end
  end

  assign Ready       = ready;
  assign IO_Out      = io_out_q;
  assign Misaligned  = misaligned_q;
  assign Range_Err   = range_err_q;
  assign Write_Count = wr_count_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed, table-driven bench for data_memory_unit (DEPTH=64, WIDTH=32).
// Optional build macro: DMEM_BYTE_EN enables the byte-enable sequence.
module tb_data_memory_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] RD;
  logic        Ready;
  logic [31:0] IO_Out;
  logic        Misaligned;
  logic        Range_Err;
  logic [15:0] Write_Count;

  int n_cmp  = 0;
  int n_fail = 0;

  data_memory_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .A           (A),
    .WD          (WD),
    .WE          (WE),
`ifdef DMEM_BYTE_EN
    .BE          (BE),
`endif
    .RD          (RD),
    .Ready       (Ready),
    .IO_Out      (IO_Out),
    .Misaligned  (Misaligned),
    .Range_Err   (Range_Err),
    .Write_Count (Write_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd_a;
    logic [31:0] exp_rd;
    logic [15:0] exp_cnt;
    logic        exp_mis;
    logic        exp_rerr;
    logic [31:0] exp_io;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Count rising edges until Ready goes high, bounded at 200 edges.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!Ready && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0010, 32'h1234_5678, 16'd1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0013, 32'h1234_5678, 16'd1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h1234_5678, 16'd1, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 32'h0000_0000, 32'h0102_0304, 16'd2, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'h0000_0055, 32'h0000_0100, 32'h0,         16'd2, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 32'h0102_0304, 16'd2, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_00A5, 32'hFFFF_FFFC, 32'h0000_00A5, 16'd3, 1'b1, 1'b1, 32'hA5};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_CAFE, 32'h0000_00FC, 32'h0BAD_CAFE, 16'd4, 1'b1, 1'b1, 32'hA5};
    vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h0000_00FF, 32'h0BAD_CAFE, 16'd4, 1'b1, 1'b1, 32'hA5};
    vecs[9]  = '{1'b1, 32'hFFFF_FFF8, 32'h0000_0001, 32'hFFFF_FFF8, 32'h0,         16'd4, 1'b1, 1'b1, 32'hA5};
    vecs[10] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0007, 32'hFFFF_FFFC, 32'h0000_00A5, 16'd4, 1'b1, 1'b1, 32'hA5};
    vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'h0,         16'd5, 1'b1, 1'b1, 32'h0};

    RST = 1'b1;
    A   = 32'h0;
    WD  = 32'h0;
    WE  = 1'b0;
    BE  = 4'hF;

    // Reset state.
    tick();
    tick();
    check("rst_ready", {31'b0, Ready}, 32'h0);
    check("rst_io", IO_Out, 32'h0);
    check("rst_mis", {31'b0, Misaligned}, 32'h0);
    check("rst_rerr", {31'b0, Range_Err}, 32'h0);
    check("rst_cnt", {16'b0, Write_Count}, 32'h0);
    check("rst_rd", RD, 32'h0);

    // First clear: exactly 64 edges to Ready.
    RST = 1'b0;
    wait_ready(edges);
    check("clear_edges", edges, 32'd64);
    foreach (vecs[i]) begin end
    A = 32'h0;  #1; check("rd_0x00", RD, 32'h0);
    A = 32'h4;  #1; check("rd_0x04", RD, 32'h0);
    A = 32'hFC; #1; check("rd_0xFC", RD, 32'h0);

    // Preload mem[5].
    A = 32'h14; WD = 32'hDEAD_BEEF; WE = 1'b1;
    tick();
    WE = 1'b0;
    #1;
    check("preload_rd", RD, 32'hDEAD_BEEF);

    // Reset, then read mem[5] during CLEAR before the sequencer reaches it: must be 0.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    tick();
    check("clear_ready_low", {31'b0, Ready}, 32'h0);
    check("clear_rd_zero", RD, 32'h0);

    // Advance to clr_idx = 20, then pulse reset; WE held high through the restarted clear.
    for (int i = 2; i < 20; i++) tick();
    RST = 1'b1;
    #1;
    check("midclr_ready", {31'b0, Ready}, 32'h0);
    tick();
    A = 32'h18; WD = 32'hCAFE_F00D; WE = 1'b1;
    RST = 1'b0;
    wait_ready(edges);
    WE = 1'b0;
    check("restart_edges", edges, 32'd64);
    A = 32'h14; #1; check("restart_rd_0x14", RD, 32'h0);
    A = 32'h18; #1; check("clear_we_ignored", RD, 32'h0);
    check("clear_cnt", {16'b0, Write_Count}, 32'h0);
    check("clear_mis", {31'b0, Misaligned}, 32'h0);
    check("clear_rerr", {31'b0, Range_Err}, 32'h0);

    // Table-driven write/read vectors in RUN.
    for (int i = 0; i < 12; i++) begin
      A  = vecs[i].a;
      WD = vecs[i].wd;
      WE = vecs[i].we;
      tick();
      WE = 1'b0;
      A  = vecs[i].rd_a;
      #1;
      check($sformatf("v%0d_rd", i), RD, vecs[i].exp_rd);
      check($sformatf("v%0d_cnt", i), {16'b0, Write_Count}, {16'b0, vecs[i].exp_cnt});
      check($sformatf("v%0d_mis", i), {31'b0, Misaligned}, {31'b0, vecs[i].exp_mis});
      check($sformatf("v%0d_rerr", i), {31'b0, Range_Err}, {31'b0, vecs[i].exp_rerr});
      check($sformatf("v%0d_io", i), IO_Out, vecs[i].exp_io);
    end

    // Same-address read during write: old data until the edge, new data after.
    A = 32'h10; WD = 32'h1111_1111; WE = 1'b1;
    #1;
    check("rw_old", RD, 32'h1234_5678);
    tick();
    WE = 1'b0;
    #1;
    check("rw_new", RD, 32'h1111_1111);
    check("rw_cnt", {16'b0, Write_Count}, 32'd6);
    check("mis_sticky", {31'b0, Misaligned}, 32'h1);

`ifdef DMEM_BYTE_EN
    // Byte enables on RAM and IO_Out.
    A = 32'h8; WD = 32'h1122_3344; BE = 4'hF; WE = 1'b1;
    tick();
    WD = 32'hAABB_CCDD; BE = 4'b0101;
    tick();
    WE = 1'b0;
    #1;
    check("be_ram", RD, 32'h11BB_33DD);
    check("be_cnt", {16'b0, Write_Count}, 32'd8);
    WD = 32'hFFFF_FFFF; BE = 4'b0000; WE = 1'b1;
    tick();
    WE = 1'b0;
    #1;
    check("be_none_data", RD, 32'h11BB_33DD);
    check("be_none_cnt", {16'b0, Write_Count}, 32'd9);
    A = 32'hFFFF_FFFC; WD = 32'hAABB_CCDD; BE = 4'b1000; WE = 1'b1;
    tick();
    WE = 1'b0;
    BE = 4'hF;
    #1;
    check("be_io", IO_Out, 32'hAA00_0000);
    check("be_io_cnt", {16'b0, Write_Count}, 32'd10);
`endif

    // Reset clears flags, counter and IO_Out; RD is 0 in CLEAR.
    RST = 1'b1;
    A = 32'h10;
    #1;
    check("final_io", IO_Out, 32'h0);
    check("final_mis", {31'b0, Misaligned}, 32'h0);
    check("final_rerr", {31'b0, Range_Err}, 32'h0);
    check("final_cnt", {16'b0, Write_Count}, 32'h0);
    check("final_ready", {31'b0, Ready}, 32'h0);
    check("final_rd", RD, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Data-memory responder for the single-cycle MIPS core. It serves the datapath's load/store port: ALU_Result is the address, WriteData is the store data and ReadData is returned. Provides:
- word-addressed RAM, zero-initialised after every reset by a clear sequencer;
- one memory-mapped output register;
- sticky error flags and an accepted-write counter for debug and verification.

Parameters:
WIDTH, 32, data and address width in bits
DEPTH, 64, number of WIDTH-bit words in the RAM; power of two, >= 2
MMIO_ADDR, 32'hFFFF_FFFC, byte address of the memory-mapped output register

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
A  input  WIDTH  byte address (datapath ALU_Result)
WD  input  WIDTH  store data (datapath WriteData)
WE  input  1  write enable (control unit MemWrite)
RD  output  WIDTH  load data (datapath ReadData), combinational
Ready  output  1  high once the clear sequence is done; top level holds the core in reset while low
IO_Out  output  WIDTH  memory-mapped output register
Misaligned  output  1  sticky: a write with A[1:0] != 0 was seen
Range_Err  output  1  sticky: a write to an unmapped address was seen
Write_Count  output  16  count of accepted writes, saturating
BE  input  4  byte enables; present only with DMEM_BYTE_EN

Behaviour:
- Word index = A[log2(DEPTH)+1:2]. In-range means A < 4*DEPTH. MMIO hit means A == MMIO_ADDR.
- FSM states:
  - CLEAR: Ready=0; each cycle writes mem[clr_idx] <= 0 and increments clr_idx. At clr_idx == DEPTH-1 it performs that write and moves to RUN.
  - RUN: Ready=1.
  - Clearing takes exactly DEPTH rising edges after RST deasserts; Ready is high on the cycle after edge DEPTH.
- Reset (asynchronous, any time, including mid-clear): state=CLEAR, clr_idx=0, IO_Out=0, Misaligned=0, Range_Err=0, Write_Count=0. The clear restarts from index 0.
- RD:
  - CLEAR: 0.
  - RUN, MMIO hit: IO_Out.
  - RUN, in range: mem[index]; A[1:0] is ignored for reads.
  - Otherwise: 0.
  - Asynchronous read. On a same-address read and write, RD shows the old data until the edge, then the new data.
- Writes in RUN take effect on the rising edge when WE=1, with this priority:
  1. A[1:0] != 0: write dropped; Misaligned <= 1.
  2. MMIO hit: IO_Out <= WD.
  3. In range: mem[index] <= WD.
  4. Otherwise: write dropped; Range_Err <= 1.
- Accepted writes are cases 2 and 3. Each increments Write_Count, which holds at 16'hFFFF.
- WE during CLEAR is ignored. It sets no flags and does not count.
- Flags are cleared only by RST.
- Address wrap: none. Addresses beyond the RAM alias nothing.

Optional Feature:
DMEM_BYTE_EN:
- Defined: adds the BE[3:0] port. An accepted write updates only the bytes whose BE bit is 1 (BE[0]=bits 7:0); this applies to both RAM and IO_Out. BE=4'b0000 with a valid address counts as accepted but changes no data.
- Undefined: BE port absent; all writes are full-word.

Decomposition:
- Package dmem_pkg:
  - state enum {CLEAR, RUN};
  - default MMIO_ADDR constant;
  - Write_Count width constant (16);
  - index-width function (clog2 of DEPTH).
- One sub-module, dmem_clear_seq: CLEAR/RUN FSM plus the clr_idx counter. Outputs Ready, clr_we and clr_idx. The RAM write-port mux lives in data_memory_unit.

Test Plan:
- Reset, then release RST with WE=0 and DEPTH=64 -> Ready=0 for 64 edges then 1. RD=0 at A=0x0, 0x4, 0xFC.
- Preload mem[5]=0xDEADBEEF, assert RST for 1 cycle at clr_idx=20 -> clear restarts at 0. After 64 edges Ready=1 and A=0x14 reads 0.
- RUN, WE=1, A=0x10, WD=0x12345678 -> next cycle RD=0x12345678 at A=0x10 and Write_Count=1. Read at A=0x13 also returns 0x12345678.
- WE=1, A=0x11, WD=0xFFFFFFFF -> mem[4] unchanged, Misaligned=1, Write_Count unchanged. Flag persists until RST.
- WE=1, A=0x100 -> Range_Err=1, RD=0. WE=1, A=0xFFFFFFFC, WD=0xA5 -> IO_Out=0xA5 and RD at that address = 0xA5.
- With DMEM_BYTE_EN, mem[2]=0x11223344, write A=0x8, WD=0xAABBCCDD, BE=4'b0101 -> mem[2]=0x11BB33DD.
